// File: rtl/n_bit_updown_count_prog_if.sv
// Control and status bundle for the programmable up/down counter.
// The master drives range/step/mode controls; the slave returns count state.
interface n_bit_updown_count_prog_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
);
   logic              en;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic              up_down;
   logic [1:0]        mode;
   logic [WIDTH-1:0]  limit;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  count;
   logic              dir;
   logic              tc;
   logic              evt;
   logic              done;

   modport master (
      output en, load, load_val, up_down,
      output mode, limit, step,
      input  count, dir, tc, evt, done
   );

   modport slave (
      input  en, load, load_val, up_down,
      input  mode, limit, step,
      output count, dir, tc, evt, done
   );
endinterface

// File: rtl/n_bit_updown_count_prog.sv
// Programmable up/down counter: runtime limit and step, parallel load,
// wrap / saturate / ping-pong / one-shot end-of-range handling.
module n_bit_updown_count_prog #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   n_bit_updown_count_prog_if.slave  cnt_if
);
   localparam logic [1:0] M_WRAP = 2'b00;
   localparam logic [1:0] M_SAT  = 2'b01;
   localparam logic [1:0] M_PP   = 2'b10;
   localparam logic [1:0] M_ONE  = 2'b11;

   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             evt_q, evt_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   cnt_x, lim_x, stp_x;
   logic [WIDTH:0]   sum_x, dif_x;
   logic             eff_up;
   logic             hit;
   logic [WIDTH-1:0] clamp_v;

   assign cnt_x = {1'b0, count_q};
   assign lim_x = {1'b0, cnt_if.limit};
   assign stp_x = (WIDTH + 1)'(cnt_if.step);
   assign sum_x = cnt_x + stp_x;
   assign dif_x = cnt_x - stp_x;

   // ping-pong keeps its own direction; other modes follow up_down live
   assign eff_up  = (cnt_if.mode == M_PP) ? dir_q : cnt_if.up_down;
   assign hit     = eff_up ? (sum_x > lim_x) : (stp_x > cnt_x);
   assign clamp_v = eff_up ? cnt_if.limit : '0;

   always_comb begin
      count_d = count_q;
      dir_d   = (cnt_if.mode == M_PP) ? dir_q : cnt_if.up_down;
      evt_d   = 1'b0;
      done_d  = done_q;
      if (cnt_if.load) begin
         count_d = (cnt_if.load_val > cnt_if.limit) ?
                   cnt_if.limit : cnt_if.load_val;
         dir_d   = cnt_if.up_down;
         done_d  = 1'b0;
      end else if (!cnt_if.en || done_q) begin
         count_d = count_q;
      end else if (count_q > cnt_if.limit) begin
         count_d = cnt_if.limit;
         evt_d   = 1'b1;
      end else if (cnt_if.step == '0) begin
         count_d = count_q;
      end else if (!hit) begin
         count_d = eff_up ? sum_x[WIDTH-1:0] : dif_x[WIDTH-1:0];
      end else begin
         evt_d = 1'b1;
         unique case (cnt_if.mode)
            M_WRAP: count_d = eff_up ? '0 : cnt_if.limit;
            M_SAT:  count_d = clamp_v;
            M_PP: begin
               count_d = clamp_v;
               dir_d   = ~dir_q;
            end
            M_ONE: begin
               count_d = clamp_v;
               done_d  = 1'b1;
            end
            default: count_d = clamp_v;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         dir_q   <= 1'b1;
         evt_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
         evt_q   <= evt_d;
         done_q  <= done_d;
      end
   end

   assign cnt_if.count = count_q;
   assign cnt_if.dir   = dir_q;
   assign cnt_if.evt   = evt_q;
   assign cnt_if.done  = done_q;
   assign cnt_if.tc    = cnt_if.en & ~done_q &
                         (count_q == (dir_q ? cnt_if.limit : '0));
endmodule

// File: tb/tb_n_bit_updown_count_prog.sv
// Scoreboard bench for n_bit_updown_count_prog: expected states are queued
// as each cycle's stimulus is driven and compared after the clock edge.
module tb_n_bit_updown_count_prog;
   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;

   typedef struct {
      string tag;
      int    count;
      int    dir;
      int    evt;
      int    done;
   } exp_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   exp_t sb_q[$];

   n_bit_updown_count_prog_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus_if ();

   n_bit_updown_count_prog #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .cnt_if (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; etc < 0 skips the pre-edge tc check.
   task automatic apply_vec(
      input string tag,
      input logic rst, input logic ld, input logic e,
      input logic ud, input logic [1:0] md,
      input int lv, input int lim, input int stp,
      input int ec, input int ed, input int ee, input int edn,
      input int etc
   );
      exp_t x;
      exp_t y;
      @(negedge clk);
      reset           = rst;
      bus_if.load     = ld;
      bus_if.en       = e;
      bus_if.up_down  = ud;
      bus_if.mode     = md;
      bus_if.load_val = WIDTH'(lv);
      bus_if.limit    = WIDTH'(lim);
      bus_if.step     = STEP_W'(stp);
      #1;
      if (etc >= 0) chk({tag, ".tc"}, 32'(bus_if.tc), 32'(etc));
      x.tag = tag; x.count = ec; x.dir = ed; x.evt = ee; x.done = edn;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         y = sb_q.pop_front();
         chk({y.tag, ".count"}, 32'(bus_if.count), 32'(y.count));
         chk({y.tag, ".dir"},   32'(bus_if.dir),   32'(y.dir));
         chk({y.tag, ".evt"},   32'(bus_if.evt),   32'(y.evt));
         chk({y.tag, ".done"},  32'(bus_if.done),  32'(y.done));
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus_if.en = 1'b0; bus_if.load = 1'b0; bus_if.up_down = 1'b1;
      bus_if.mode = 2'b00; bus_if.load_val = '0;
      bus_if.limit = 8'd9; bus_if.step = 4'd1;

      // reset state, even with load/en requested
      apply_vec("rst", 1, 1, 1, 1, 2'b00, 77, 200, 1, 0, 1, 0, 0, -1);

      // wrap up 0..9 then 0 with event; tc only at 9
      for (int i = 1; i <= 10; i++)
         apply_vec("wrap_up", 0, 0, 1, 1, 2'b00, 0, 9, 1,
                   i % 10, 1, (i == 10) ? 1 : 0, 0, (i == 10) ? 1 : 0);

      // wrap down step 4 from 5: 1, 9 (evt), 5
      apply_vec("wrap_dn_ld", 0, 1, 0, 0, 2'b00, 5, 9, 4, 5, 0, 0, 0, -1);
      apply_vec("wrap_dn",    0, 0, 1, 0, 2'b00, 0, 9, 4, 1, 0, 0, 0, 0);
      apply_vec("wrap_dn",    0, 0, 1, 0, 2'b00, 0, 9, 4, 9, 0, 1, 0, 0);
      apply_vec("wrap_dn",    0, 0, 1, 0, 2'b00, 0, 9, 4, 5, 0, 0, 0, 0);

      // saturate up from 190, step 15, limit 200
      apply_vec("sat_ld", 0, 1, 0, 1, 2'b01, 190, 200, 15, 190, 1, 0, 0, -1);
      apply_vec("sat", 0, 0, 1, 1, 2'b01, 0, 200, 15, 200, 1, 1, 0, 0);
      apply_vec("sat", 0, 0, 1, 1, 2'b01, 0, 200, 15, 200, 1, 1, 0, 1);
      apply_vec("sat", 0, 0, 1, 1, 2'b01, 0, 200, 15, 200, 1, 1, 0, 1);

      // ping-pong, limit 3 step 2; up_down driven 0 must be ignored
      apply_vec("pp_ld", 0, 1, 0, 1, 2'b10, 0, 3, 2, 0, 1, 0, 0, -1);
      apply_vec("pp", 0, 0, 1, 0, 2'b10, 0, 3, 2, 2, 1, 0, 0, 0);
      apply_vec("pp", 0, 0, 1, 0, 2'b10, 0, 3, 2, 3, 0, 1, 0, 0);
      apply_vec("pp", 0, 0, 1, 0, 2'b10, 0, 3, 2, 1, 0, 0, 0, 0);
      apply_vec("pp", 0, 0, 1, 0, 2'b10, 0, 3, 2, 0, 1, 1, 0, 0);
      apply_vec("pp", 0, 0, 1, 0, 2'b10, 0, 3, 2, 2, 1, 0, 0, 0);

      // one-shot down from 7 step 3: 4, 1, 0 done; then held; load clears
      apply_vec("os_ld", 0, 1, 0, 0, 2'b11, 7, 7, 3, 7, 0, 0, 0, -1);
      apply_vec("os", 0, 0, 1, 0, 2'b11, 0, 7, 3, 4, 0, 0, 0, 0);
      apply_vec("os", 0, 0, 1, 0, 2'b11, 0, 7, 3, 1, 0, 0, 0, 0);
      apply_vec("os", 0, 0, 1, 0, 2'b11, 0, 7, 3, 0, 0, 1, 1, 0);
      apply_vec("os_held", 0, 0, 1, 0, 2'b11, 0, 7, 3, 0, 0, 0, 1, 0);
      apply_vec("os_held", 0, 0, 1, 0, 2'b11, 0, 7, 3, 0, 0, 0, 1, 0);
      apply_vec("os_reld", 0, 1, 1, 0, 2'b11, 5, 7, 3, 5, 0, 0, 0, -1);

      // limit lowered under a running count
      apply_vec("lim_ld", 0, 1, 0, 1, 2'b00, 50, 100, 1, 50, 1, 0, 0, -1);
      apply_vec("lim_dn", 0, 0, 1, 1, 2'b00, 0, 20, 1, 20, 1, 1, 0, 0);
      apply_vec("lim_nx", 0, 0, 1, 1, 2'b00, 0, 20, 1, 0, 1, 1, 0, 1);
      apply_vec("rst_ld", 1, 1, 1, 0, 2'b00, 9, 20, 1, 0, 1, 0, 0, -1);

      // load above limit clamps; en=0 holds; step=0 holds
      apply_vec("ld_clamp", 0, 1, 0, 1, 2'b01, 250, 100, 5, 100, 1, 0, 0, -1);
      apply_vec("en_off", 0, 0, 0, 1, 2'b01, 0, 100, 5, 100, 1, 0, 0, 0);
      apply_vec("step0", 0, 0, 1, 1, 2'b01, 0, 100, 0, 100, 1, 0, 0, 1);

      // limit 0: count pinned at 0, every nonzero step is an event
      apply_vec("lim0_ld", 0, 1, 0, 1, 2'b00, 33, 0, 3, 0, 1, 0, 0, -1);
      apply_vec("lim0", 0, 0, 1, 1, 2'b00, 0, 0, 3, 0, 1, 1, 0, 1);
      apply_vec("lim0", 0, 0, 1, 1, 2'b00, 0, 0, 3, 0, 1, 1, 0, 1);

      if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
